// File: rtl/sysbus_arbiter.sv
// Two-requester Sysbus arbiter: icache and dcache share one master port.
// Grants are held until the owner pulses busidle, with round-robin tie-breaks and a sticky hold watchdog.
module sysbus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MAX_HOLD       = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      icache_busreq,
  input  logic                      icache_busidle,
  output logic                      icache_busgrant,
  input  logic                      dcache_busreq,
  input  logic                      dcache_busidle,
  output logic                      dcache_busgrant,
  input  logic                      i_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] i_req,
  input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
  input  logic                      i_respack,
  output logic                      i_reqack,
  output logic                      i_respcyc,
  input  logic                      d_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] d_req,
  input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
  input  logic                      d_respack,
  output logic                      d_reqack,
  output logic                      d_respcyc,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_respack,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  output logic                      timeout_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              last_was_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_inc;
  logic              granted;
  logic              hold_sat;

  // Grant only from IDLE, so every release is followed by one turnaround cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (icache_busreq && dcache_busreq) state_next = last_was_d ? GNT_I : GNT_D;
        else if (dcache_busreq)             state_next = GNT_D;
        else if (icache_busreq)             state_next = GNT_I;
      end
      GNT_I:   if (icache_busidle) state_next = IDLE;
      GNT_D:   if (dcache_busidle) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_was_d <= 1'b0;
    end else begin
      state <= state_next;
      if (state == GNT_I && state_next == IDLE) last_was_d <= 1'b0;
      if (state == GNT_D && state_next == IDLE) last_was_d <= 1'b1;
    end
  end

  assign granted  = (state != IDLE);
  assign hold_inc = hold_cnt + 1'b1;
  assign hold_sat = (hold_cnt == HOLD_LIMIT);

  // The releasing cycle still counts as a granted cycle before the counter clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!granted || state_next == IDLE) hold_cnt <= '0;
      else if (!hold_sat)                 hold_cnt <= hold_inc;
      if (MAX_HOLD != 0 && granted && !hold_sat && hold_inc == HOLD_LIMIT)
        timeout_err <= 1'b1;
    end
  end

  assign icache_busgrant = (state == GNT_I);
  assign dcache_busgrant = (state == GNT_D);

  always_comb begin
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    if (icache_busgrant) begin
      bus_reqcyc  = i_reqcyc;
      bus_req     = i_req;
      bus_reqtag  = i_reqtag;
      bus_respack = i_respack;
    end else if (dcache_busgrant) begin
      bus_reqcyc  = d_reqcyc;
      bus_req     = d_req;
      bus_reqtag  = d_reqtag;
      bus_respack = d_respack;
    end
  end

  assign i_reqack  = bus_reqack  & icache_busgrant;
  assign d_reqack  = bus_reqack  & dcache_busgrant;
  assign i_respcyc = bus_respcyc & icache_busgrant;
  assign d_respcyc = bus_respcyc & dcache_busgrant;

endmodule
